// File: rtl/qsys_irq_ctrl.sv
// Purpose : Avalon-MM interrupt controller; latches level/edge irq sources, masks, priority-encodes, drives one irq.
// Latency : irq_in -> irq_out 3 clk edges (5 with QSYS_IRQ_CTRL_SYNC_EN); readdata valid 1 cycle after address.
// Backpress: none; slave always accepts, zero wait states. Optional macro QSYS_IRQ_CTRL_SYNC_EN adds a 2-flop input synchronizer.
module qsys_irq_ctrl #(
  parameter int NUM_IRQ = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               chipselect,
  input  logic [2:0]         address,
  input  logic               write_n,
  input  logic [15:0]        writedata,
  output logic [15:0]        readdata,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic               irq_out
);

  localparam logic [2:0] ADDR_PENDING = 3'd0;
  localparam logic [2:0] ADDR_ENABLE  = 3'd1;
  localparam logic [2:0] ADDR_EDGE    = 3'd2;
  localparam logic [2:0] ADDR_ACTIVE  = 3'd3;
  localparam logic [2:0] ADDR_RAW     = 3'd4;
  localparam logic [2:0] ADDR_SWTRIG  = 3'd5;

  typedef logic [NUM_IRQ-1:0] vec_t;

  logic        wr;
  vec_t        wdat;
  vec_t        irq_src;
  vec_t        irq_q, irq_d;
  vec_t        pending_q, pending_d;
  vec_t        enable_q, enable_d;
  vec_t        edge_q, edge_d;
  vec_t        masked;
  logic        active_vld;
  logic [3:0]  active_id;
  logic [15:0] readdata_q, readdata_d;
  logic        irq_out_q, irq_out_d;
  logic        unused_wdat;

  assign wr          = chipselect & ~write_n;
  assign wdat        = writedata[NUM_IRQ-1:0];
  // upper write-data bits are don't-care when fewer than 16 sources exist
  assign unused_wdat = ^writedata;

  function automatic logic [15:0] zext(input vec_t v);
    zext = '0;
    zext[NUM_IRQ-1:0] = v;
  endfunction

`ifdef QSYS_IRQ_CTRL_SYNC_EN
  vec_t sync1_q, sync2_q;

  // two-flop synchronizer for sources outside the clk domain
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_in;
      sync2_q <= sync1_q;
    end
  end

  assign irq_src = sync2_q;
`else
  assign irq_src = irq_in;
`endif

  // input stage: current and previous sample for rising-edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_q <= '0;
      irq_d <= '0;
    end else begin
      irq_q <= irq_src;
      irq_d <= irq_q;
    end
  end

  // next-state for PENDING/ENABLE/EDGE from sources and bus writes
  always_comb begin
    pending_d = pending_q;
    enable_d  = enable_q;
    edge_d    = edge_q;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (wr && address == ADDR_EDGE && wdat[i] != edge_q[i]) begin
        // a mode switch discards any stale request for that source
        pending_d[i] = 1'b0;
      end else if (!edge_q[i]) begin
        pending_d[i] = irq_q[i];
      end else if ((irq_q[i] & ~irq_d[i]) || (wr && address == ADDR_SWTRIG && wdat[i])) begin
        // set beats a simultaneous W1C so no edge is lost
        pending_d[i] = 1'b1;
      end else if (wr && address == ADDR_PENDING && wdat[i]) begin
        pending_d[i] = 1'b0;
      end
    end
    if (wr && address == ADDR_ENABLE) enable_d = wdat;
    if (wr && address == ADDR_EDGE)   edge_d   = wdat;
  end

  // lowest-index enabled pending source wins
  always_comb begin
    masked     = pending_q & enable_q;
    active_vld = |masked;
    active_id  = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (masked[i]) active_id = 4'(i);
    end
  end

  // read mux and output request, both registered
  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_PENDING: readdata_d = zext(pending_q);
      ADDR_ENABLE:  readdata_d = zext(enable_q);
      ADDR_EDGE:    readdata_d = zext(edge_q);
      ADDR_ACTIVE:  readdata_d = active_vld ? {1'b1, 11'd0, active_id} : 16'h0000;
      ADDR_RAW:     readdata_d = zext(irq_q);
      default:      readdata_d = '0;
    endcase
    irq_out_d = active_vld;
  end

  // control/status register bank
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q  <= '0;
      enable_q   <= '0;
      edge_q     <= '0;
      readdata_q <= '0;
      irq_out_q  <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      enable_q   <= enable_d;
      edge_q     <= edge_d;
      readdata_q <= readdata_d;
      irq_out_q  <= irq_out_d;
    end
  end

  assign readdata = readdata_q;
  assign irq_out  = irq_out_q;

endmodule

// File: tb/tb_qsys_irq_ctrl.sv
// Bench for qsys_irq_ctrl: directed scenarios with literal expectations plus randomized bus/irq traffic,
// every cycle compared against a vector-level reference model of the register semantics.
// Inputs driven on falling edges; outputs sampled on falling edges.
module tb_qsys_irq_ctrl;

`ifdef QSYS_IRQ_CTRL_SYNC_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 3;
`endif
  localparam logic [15:0] MASK = 16'h00FF;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        chipselect = 1'b0;
  logic [2:0]  address = 3'd0;
  logic        write_n = 1'b1;
  logic [15:0] writedata = 16'h0;
  logic [15:0] readdata;
  logic [7:0]  irq_in = 8'h0;
  logic        irq_out;

  int n_tests = 0;
  int n_fail  = 0;

  qsys_irq_ctrl #(.NUM_IRQ(8)) dut (
    .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .address(address),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .irq_in(irq_in), .irq_out(irq_out)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (whole-vector arithmetic) ----------------
  logic [15:0] m_s1, m_s2, m_q, m_d, m_pend, m_en, m_edge, m_rd;
  logic        m_out;

  function automatic logic [15:0] model_pending(input logic wr, input logic [2:0] a, input logic [15:0] wd,
                                                input logic [15:0] q, input logic [15:0] d,
                                                input logic [15:0] pend, input logic [15:0] edg);
    logic [15:0] chg, setv, clrv, edge_part, level_part;
    chg        = (wr && a == 3'd2) ? (wd ^ edg) : 16'h0;
    setv       = ((q & ~d) | ((wr && a == 3'd5) ? wd : 16'h0)) & edg;
    clrv       = ((wr && a == 3'd0) ? wd : 16'h0) & edg;
    edge_part  = (setv | (pend & ~clrv)) & edg;
    level_part = q & ~edg;
    return (edge_part | level_part) & ~chg & MASK;
  endfunction

  function automatic logic [15:0] model_read(input logic [2:0] a, input logic [15:0] pend,
                                             input logic [15:0] en, input logic [15:0] edg,
                                             input logic [15:0] raw);
    logic [15:0] m;
    m = pend & en;
    case (a)
      3'd0: return pend;
      3'd1: return en;
      3'd2: return edg;
      3'd3: begin
        for (int i = 0; i < 16; i++) if (m[i]) return 16'h8000 + 16'(i);
        return 16'h0000;
      end
      3'd4: return raw;
      default: return 16'h0000;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_s1 <= '0; m_s2 <= '0; m_q <= '0; m_d <= '0;
      m_pend <= '0; m_en <= '0; m_edge <= '0; m_rd <= '0; m_out <= 1'b0;
    end else begin
      m_s1 <= {8'h0, irq_in};
      m_s2 <= m_s1;
`ifdef QSYS_IRQ_CTRL_SYNC_EN
      m_q <= m_s2;
`else
      m_q <= {8'h0, irq_in};
`endif
      m_d    <= m_q;
      m_pend <= model_pending(chipselect & ~write_n, address, writedata & MASK, m_q, m_d, m_pend, m_edge);
      if (chipselect && !write_n && address == 3'd1) m_en   <= writedata & MASK;
      if (chipselect && !write_n && address == 3'd2) m_edge <= writedata & MASK;
      m_out <= (m_pend & m_en) != 16'h0;
      m_rd  <= model_read(address, m_pend, m_en, m_edge, m_q);
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
    end
  endtask

  // advance one cycle, then compare registered outputs with the model
  task automatic tick();
    @(negedge clk);
    chk("cyc_readdata", readdata, m_rd);
    chk("cyc_irq_out", {15'h0, irq_out}, {15'h0, m_out});
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [15:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_rd(input string name, input logic [2:0] a, input logic [15:0] exp);
    chipselect = 1'b1; write_n = 1'b1; address = a;
    tick();
    chk(name, readdata, exp);
    chipselect = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    // reset state of every address
    for (int a = 0; a < 8; a++) bus_rd("reset_read", 3'(a), 16'h0000);
    chk("reset_irq_out", {15'h0, irq_out}, 16'h0);

    // level source 0: latency in and out, W1C ignored
    bus_wr(3'd1, 16'h0001);
    bus_wr(3'd2, 16'h0000);
    irq_in = 8'h01;
    repeat (LAT - 1) tick();
    chk("lvl_lat_before", {15'h0, irq_out}, 16'h0);
    tick();
    chk("lvl_lat_at", {15'h0, irq_out}, 16'h1);
    bus_rd("lvl_active", 3'd3, 16'h8000);
    bus_rd("lvl_raw", 3'd4, 16'h0001);
    bus_wr(3'd0, 16'h0001);
    bus_rd("lvl_w1c_ignored", 3'd0, 16'h0001);
    chk("lvl_w1c_irq", {15'h0, irq_out}, 16'h1);
    irq_in = 8'h00;
    repeat (LAT - 1) tick();
    chk("lvl_drop_before", {15'h0, irq_out}, 16'h1);
    tick();
    chk("lvl_drop_at", {15'h0, irq_out}, 16'h0);

    // edge source 2: one-cycle pulse is latched, W1C drops irq next edge
    bus_wr(3'd2, 16'h0004);
    bus_wr(3'd1, 16'h0004);
    irq_in = 8'h04;
    tick();
    irq_in = 8'h00;
    repeat (LAT + 1) tick();
    bus_rd("edge_pending", 3'd0, 16'h0004);
    bus_rd("edge_active", 3'd3, 16'h8002);
    chk("edge_irq", {15'h0, irq_out}, 16'h1);
    bus_wr(3'd0, 16'h0004);
    chk("w1c_irq_same_edge", {15'h0, irq_out}, 16'h1);
    tick();
    chk("w1c_irq_next_edge", {15'h0, irq_out}, 16'h0);

    // W1C coincident with a new rising edge: set wins
    irq_in = 8'h04;
    repeat (LAT - 2) tick();
    bus_wr(3'd0, 16'h0004);
    bus_rd("set_beats_w1c", 3'd0, 16'h0004);
    // held high: no re-capture after clearing
    bus_wr(3'd0, 16'h0004);
    tick();
    bus_rd("held_no_recapture", 3'd0, 16'h0000);
    irq_in = 8'h00;
    repeat (LAT) tick();
    // SWTRIG only affects edge sources
    bus_wr(3'd5, 16'h0006);
    bus_rd("swtrig_edge_only", 3'd0, 16'h0004);
    bus_rd("swtrig_reads0", 3'd5, 16'h0000);
    bus_wr(3'd0, 16'h0004);

    // priority and masking with level sources 3 and 5
    bus_wr(3'd2, 16'h0000);
    bus_wr(3'd1, 16'h00FF);
    irq_in = 8'h28;
    repeat (LAT + 1) tick();
    bus_rd("prio_active", 3'd3, 16'h8003);
    chk("prio_irq", {15'h0, irq_out}, 16'h1);
    bus_wr(3'd1, 16'h00F7);
    bus_rd("mask_active", 3'd3, 16'h8005);
    bus_rd("mask_pending", 3'd0, 16'h0028);
    bus_wr(3'd1, 16'h0000);
    tick();
    chk("mask_all_irq", {15'h0, irq_out}, 16'h0);
    bus_rd("mask_all_active", 3'd3, 16'h0000);

    // asynchronous reset while requesting
    bus_wr(3'd1, 16'h00FF);
    repeat (2) tick();
    bus_rd("pre_reset_pending", 3'd0, 16'h0028);
    chk("pre_reset_irq", {15'h0, irq_out}, 16'h1);
    #2 reset_n = 1'b0;
    irq_in = 8'h00;
    #1;
    chk("async_reset_irq", {15'h0, irq_out}, 16'h0);
    chk("async_reset_rd", readdata, 16'h0000);
    repeat (2) tick();
    reset_n = 1'b1;
    for (int a = 0; a < 8; a++) bus_rd("post_reset_read", 3'(a), 16'h0000);
    chk("post_reset_irq", {15'h0, irq_out}, 16'h0);

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      chipselect = 1'($urandom_range(0, 1));
      write_n    = ($urandom_range(0, 3) != 0);
      address    = 3'($urandom_range(0, 7));
      writedata  = 16'($urandom);
      for (int b = 0; b < 8; b++) if ($urandom_range(0, 7) == 0) irq_in[b] = ~irq_in[b];
      tick();
    end
    chipselect = 1'b0; write_n = 1'b1;
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
